// File: rtl/score_keeper.sv
// score_keeper: BCD run score, 100-point milestone pulse, best score when HIGH_SCORE_EN is defined
module score_keeper #(
  parameter int DIGITS = 5,
  parameter int TICKS_PER_POINT = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          game_state,
  input  logic                frame_tick,
  output logic [4*DIGITS-1:0] score,
  output logic [4*DIGITS-1:0] high_score,
  output logic                new_record,
  output logic                milestone
);
  localparam int W = 4*DIGITS;
  localparam int LW = DIGITS > 1 ? 8 : 4;
  localparam logic [7:0] LAST = 8'(TICKS_PER_POINT - 1);
  typedef enum logic [1:0] {INIT = 2'b00, IN_GAME = 2'b01, DEAD = 2'b10} state_t;
  state_t state, prev_state;
  logic [7:0] prescale;
  logic [W-1:0] score_inc;
  logic carry;
  assign state = game_state == 2'b00 ? INIT : game_state == 2'b01 ? IN_GAME : DEAD;
  always_comb begin
    score_inc = score;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      score_inc[4*i +: 4] = carry ? (score[4*i +: 4] == 4'd9 ? 4'd0 : score[4*i +: 4] + 4'd1) : score[4*i +: 4];
      carry = carry & (score[4*i +: 4] == 4'd9);
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      score      <= '0;
      prescale   <= '0;
      prev_state <= INIT;
      milestone  <= 1'b0;
    end else begin
      prev_state <= state;
      milestone  <= 1'b0;
      if (state == INIT || (state == IN_GAME && prev_state == INIT)) begin
        score    <= '0;
        prescale <= '0;
      end else if (state == IN_GAME && frame_tick) begin
        prescale <= prescale == LAST ? 8'd0 : prescale + 8'd1;
        if (prescale == LAST && !carry) begin
          score     <= score_inc;
          milestone <= score_inc[LW-1:0] == '0;
        end
      end
    end
`ifdef HIGH_SCORE_EN
  // packed BCD orders the same as binary, so a plain compare is MSD-first
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      high_score <= '0;
      new_record <= 1'b0;
    end else if (state == IN_GAME && prev_state == INIT) new_record <= 1'b0;
    else if (state == DEAD && prev_state == IN_GAME && score > high_score) begin
      high_score <= score;
      new_record <= 1'b1;
    end
`else
  assign high_score = '0;
  assign new_record = 1'b0;
`endif
endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: scoreboard bench for score_keeper (main DUT 5 digits/6 ticks, second DUT 3 digits/1 tick)
module tb_score_keeper;
`ifdef HIGH_SCORE_EN
  localparam bit HS = 1'b1;
`else
  localparam bit HS = 1'b0;
`endif
  logic clk, rst, frame_tick, ft2, ms1, ms2, nr1, nr2;
  logic [1:0] game_state, gs2;
  logic [19:0] score1, hs1;
  logic [11:0] score2, hs2;
  int n_checks = 0, n_fail = 0, mc1 = 0, mc2 = 0;
  typedef struct {
    int sel;
    logic [19:0] sc;
    logic [19:0] hs;
    logic nr;
    logic msl;
    int msc;
    string name;
  } exp_t;
  exp_t q[$];

  score_keeper #(.DIGITS(5), .TICKS_PER_POINT(6)) dut (
    .clk(clk), .rst(rst), .game_state(game_state), .frame_tick(frame_tick),
    .score(score1), .high_score(hs1), .new_record(nr1), .milestone(ms1));
  score_keeper #(.DIGITS(3), .TICKS_PER_POINT(1)) dut2 (
    .clk(clk), .rst(rst), .game_state(gs2), .frame_tick(ft2),
    .score(score2), .high_score(hs2), .new_record(nr2), .milestone(ms2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [19:0] act, input logic [19:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic push(input int sel, input logic [19:0] sc, input logic [19:0] hs, input logic nr,
                      input logic msl, input int msc, input string name);
    exp_t e;
    e.sel = sel; e.sc = sc; e.hs = HS ? hs : 20'h0; e.nr = HS ? nr : 1'b0;
    e.msl = msl; e.msc = msc; e.name = name;
    q.push_back(e);
  endtask

  // monitor: count milestone cycles, then retire every pending expectation
  always @(negedge clk) begin
    exp_t e;
    logic [19:0] a_sc, a_hs;
    logic a_nr, a_ms;
    int a_mc;
    if (ms1) mc1++;
    if (ms2) mc2++;
    while (q.size() > 0) begin
      e = q.pop_front();
      if (e.sel == 0) begin
        a_sc = score1; a_hs = hs1; a_nr = nr1; a_ms = ms1; a_mc = mc1;
      end else begin
        a_sc = {8'h0, score2}; a_hs = {8'h0, hs2}; a_nr = nr2; a_ms = ms2; a_mc = mc2;
      end
      chk({e.name, ".score"}, a_sc, e.sc);
      chk({e.name, ".high_score"}, a_hs, e.hs);
      chk({e.name, ".new_record"}, 20'(a_nr), 20'(e.nr));
      chk({e.name, ".milestone"}, 20'(a_ms), 20'(e.msl));
      chk({e.name, ".milestone_count"}, 20'(a_mc), 20'(e.msc));
    end
  end

  task automatic step(input int sel, input logic ft);
    if (sel == 0) frame_tick = ft; else ft2 = ft;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    ft2 = 1'b0;
  endtask

  task automatic ticks(input int sel, input int n);
    for (int i = 0; i < n; i++) step(sel, 1'b1);
  endtask

  task automatic go(input int sel, input logic [1:0] s, input logic ft);
    if (sel == 0) game_state = s; else gs2 = s;
    step(sel, ft);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; game_state = 2'b00; frame_tick = 1'b0; gs2 = 2'b00; ft2 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    push(0, 20'h0, 20'h0, 0, 0, 0, "reset");
    ticks(0, 3);
    push(0, 20'h0, 20'h0, 0, 0, 0, "init_ignores_tick");
    go(0, 2'b01, 1'b0);
    ticks(0, 60);
    push(0, 20'h00010, 20'h0, 0, 0, 0, "score10");
    ticks(0, 6);
    push(0, 20'h00011, 20'h0, 0, 0, 0, "score11");
    ticks(0, 186);
    push(0, 20'h00042, 20'h0, 0, 0, 0, "score42");
    @(posedge clk);
    #1 rst = 1'b0;
    push(0, 20'h0, 20'h0, 0, 0, 0, "async_reset");
    @(posedge clk);
    #1 rst = 1'b1;
    go(0, 2'b01, 1'b0);
    ticks(0, 120);
    go(0, 2'b10, 1'b0);
    push(0, 20'h00020, 20'h00020, 1, 0, 0, "die20_record");
    go(0, 2'b00, 1'b0);
    push(0, 20'h0, 20'h00020, 1, 0, 0, "init_keeps_record");
    go(0, 2'b01, 1'b0);
    push(0, 20'h0, 20'h00020, 0, 0, 0, "start_clears_record");
    ticks(0, 222);
    push(0, 20'h00037, 20'h00020, 0, 0, 0, "score37");
    ticks(0, 5);
    go(0, 2'b10, 1'b1);
    push(0, 20'h00037, 20'h00037, 1, 0, 0, "die37_with_tick");
    ticks(0, 12);
    push(0, 20'h00037, 20'h00037, 1, 0, 0, "dead_frozen");
    go(0, 2'b11, 1'b0);
    ticks(0, 6);
    push(0, 20'h00037, 20'h00037, 1, 0, 0, "state11_dead");
    go(0, 2'b00, 1'b0);
    push(0, 20'h0, 20'h00037, 1, 0, 0, "dead_to_init");
    go(0, 2'b01, 1'b0);
    ticks(0, 90);
    go(0, 2'b10, 1'b0);
    push(0, 20'h00015, 20'h00037, 0, 0, 0, "die15_no_record");
    go(0, 2'b00, 1'b0);
    push(0, 20'h0, 20'h00037, 0, 0, 0, "init_after15");
    go(0, 2'b01, 1'b0);
    ticks(0, 30);
    go(0, 2'b00, 1'b0);
    push(0, 20'h0, 20'h00037, 0, 0, 0, "abort_to_init");
    go(0, 2'b01, 1'b0);
    ticks(0, 594);
    push(0, 20'h00099, 20'h00037, 0, 0, 0, "score99");
    ticks(0, 6);
    push(0, 20'h00100, 20'h00037, 0, 1, 1, "score100_milestone");
    step(0, 1'b0);
    push(0, 20'h00100, 20'h00037, 0, 0, 1, "milestone_one_cycle");
    ticks(0, 594);
    push(0, 20'h00199, 20'h00037, 0, 0, 1, "score199");
    ticks(0, 6);
    push(0, 20'h00200, 20'h00037, 0, 1, 2, "score200_milestone");
    go(0, 2'b10, 1'b0);
    push(0, 20'h00200, 20'h00200, 1, 0, 2, "die200_record");
    go(1, 2'b01, 1'b0);
    ticks(1, 5);
    push(1, 20'h005, 20'h0, 0, 0, 0, "d2_score5");
    go(1, 2'b10, 1'b1);
    push(1, 20'h005, 20'h005, 1, 0, 0, "d2_die_with_tick");
    go(1, 2'b00, 1'b0);
    go(1, 2'b01, 1'b0);
    push(1, 20'h0, 20'h005, 0, 0, 0, "d2_restart");
    ticks(1, 99);
    push(1, 20'h099, 20'h005, 0, 0, 0, "d2_score99");
    ticks(1, 1);
    push(1, 20'h100, 20'h005, 0, 1, 1, "d2_score100");
    ticks(1, 899);
    push(1, 20'h999, 20'h005, 0, 0, 9, "d2_score999");
    ticks(1, 12);
    push(1, 20'h999, 20'h005, 0, 0, 9, "d2_saturated");
    go(1, 2'b10, 1'b0);
    push(1, 20'h999, 20'h999, 1, 0, 9, "d2_die999");
    repeat (3) @(negedge clk);
    chk("queue_drain", 20'(q.size()), 20'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
